// File: rtl/uart_tx_fifo_if.sv
// Byte-in / serial-out bundle of the queued UART transmitter.
// The producer holds the master side; the transmitter holds the slave side.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                 tx_dv;
  logic [DATA_BITS-1:0] tx_byte;
  logic                 tx_ready;
  logic                 tx_serial;
  logic                 tx_active;
  logic                 tx_done;
  logic                 overflow;
  logic [CW-1:0]        fifo_count;

  modport master (
    output tx_dv, tx_byte,
    input  tx_ready, tx_serial, tx_active, tx_done, overflow, fifo_count
  );

  modport slave (
    input  tx_dv, tx_byte,
    output tx_ready, tx_serial, tx_active, tx_done, overflow, fifo_count
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Queued UART transmitter: a small TX FIFO feeding a fixed-format frame serialiser.
// Frames already queued when a stop bit ends go out with no idle bit in between.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 8
) (
  input logic           i_Clock,
  input logic           i_Reset_n,
  uart_tx_fifo_if.slave bus
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int BCW = $clog2(CLKS_PER_BIT);
  localparam int IW  = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  logic [DATA_BITS-1:0] fifo_mem_r [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]        count_r, count_s;
  logic                 ready_r, overflow_r;
  logic                 wr_en_s, pop_s, have_data_s, bit_end_s;
  logic [DATA_BITS-1:0] head_s;

  state_t               state_r, state_s;
  logic [BCW-1:0]       clk_cnt_r, clk_cnt_s;
  logic [IW-1:0]        bit_idx_r, bit_idx_s;
  logic                 stop_idx_r, stop_idx_s;
  logic [DATA_BITS-1:0] shift_r, shift_s;
  logic                 parity_r, parity_s;
  logic                 serial_r, serial_s;
  logic                 active_r, active_s;
  logic                 done_r, done_s;

  // Parity is taken from the byte as popped; the shift register is consumed later.
  function automatic logic frame_parity(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~(^d) : (^d);
  endfunction

  assign wr_en_s     = bus.tx_dv & ready_r;
  assign head_s      = fifo_mem_r[rd_ptr_r];
  assign have_data_s = (count_r != {CW{1'b0}});
  assign bit_end_s   = (clk_cnt_r == BCW'(CLKS_PER_BIT - 1));

  // Occupancy after this edge; a same-cycle pop never makes room for a write when full.
  always_comb begin
    case ({wr_en_s, pop_s})
      2'b10:   count_s = count_r + CW'(1);
      2'b01:   count_s = count_r - CW'(1);
      default: count_s = count_r;
    endcase
  end

  // FIFO pointers, occupancy, ready and overflow flags.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      ready_r    <= 1'b1;
      overflow_r <= 1'b0;
    end else begin
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)   rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r    <= count_s;
      ready_r    <= (count_s != CW'(FIFO_DEPTH));
      overflow_r <= bus.tx_dv & ~ready_r;
    end
  end

  // FIFO storage; contents are meaningless until written, so no reset.
  always_ff @(posedge i_Clock) begin
    if (wr_en_s) fifo_mem_r[wr_ptr_r] <= bus.tx_byte;
  end

  // Frame sequencer: next state, next line level and pop request.
  always_comb begin
    state_s    = state_r;
    clk_cnt_s  = clk_cnt_r;
    bit_idx_s  = bit_idx_r;
    stop_idx_s = stop_idx_r;
    shift_s    = shift_r;
    parity_s   = parity_r;
    serial_s   = serial_r;
    active_s   = active_r;
    done_s     = 1'b0;
    pop_s      = 1'b0;
    case (state_r)
      S_IDLE: begin
        clk_cnt_s = {BCW{1'b0}};
        if (have_data_s) begin
          pop_s    = 1'b1;
          shift_s  = head_s;
          parity_s = frame_parity(head_s);
          serial_s = 1'b0;
          active_s = 1'b1;
          state_s  = S_START;
        end else begin
          serial_s = 1'b1;
          active_s = 1'b0;
        end
      end
      S_START: begin
        if (bit_end_s) begin
          clk_cnt_s = {BCW{1'b0}};
          bit_idx_s = {IW{1'b0}};
          serial_s  = shift_r[0];
          shift_s   = shift_r >> 1;
          state_s   = S_DATA;
        end else begin
          clk_cnt_s = clk_cnt_r + BCW'(1);
        end
      end
      S_DATA: begin
        if (bit_end_s) begin
          clk_cnt_s = {BCW{1'b0}};
          if (bit_idx_r == IW'(DATA_BITS - 1)) begin
            if (PARITY != 0) begin
              serial_s = parity_r;
              state_s  = S_PARITY;
            end else begin
              serial_s   = 1'b1;
              stop_idx_s = 1'b0;
              state_s    = S_STOP;
            end
          end else begin
            bit_idx_s = bit_idx_r + IW'(1);
            serial_s  = shift_r[0];
            shift_s   = shift_r >> 1;
          end
        end else begin
          clk_cnt_s = clk_cnt_r + BCW'(1);
        end
      end
      S_PARITY: begin
        if (bit_end_s) begin
          clk_cnt_s  = {BCW{1'b0}};
          serial_s   = 1'b1;
          stop_idx_s = 1'b0;
          state_s    = S_STOP;
        end else begin
          clk_cnt_s = clk_cnt_r + BCW'(1);
        end
      end
      S_STOP: begin
        if (bit_end_s) begin
          clk_cnt_s = {BCW{1'b0}};
          if (stop_idx_r == 1'(STOP_BITS - 1)) begin
            done_s = 1'b1;
            if (have_data_s) begin
              pop_s    = 1'b1;
              shift_s  = head_s;
              parity_s = frame_parity(head_s);
              serial_s = 1'b0;
              active_s = 1'b1;
              state_s  = S_START;
            end else begin
              serial_s = 1'b1;
              active_s = 1'b0;
              state_s  = S_IDLE;
            end
          end else begin
            stop_idx_s = 1'b1;
          end
        end else begin
          clk_cnt_s = clk_cnt_r + BCW'(1);
        end
      end
      default: begin
        clk_cnt_s = {BCW{1'b0}};
        serial_s  = 1'b1;
        active_s  = 1'b0;
        state_s   = S_IDLE;
      end
    endcase
  end

  // Sequencer registers; every output leaves the block from a flop.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_r    <= S_IDLE;
      clk_cnt_r  <= {BCW{1'b0}};
      bit_idx_r  <= {IW{1'b0}};
      stop_idx_r <= 1'b0;
      shift_r    <= {DATA_BITS{1'b0}};
      parity_r   <= 1'b0;
      serial_r   <= 1'b1;
      active_r   <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      clk_cnt_r  <= clk_cnt_s;
      bit_idx_r  <= bit_idx_s;
      stop_idx_r <= stop_idx_s;
      shift_r    <= shift_s;
      parity_r   <= parity_s;
      serial_r   <= serial_s;
      active_r   <= active_s;
      done_r     <= done_s;
    end
  end

  assign bus.tx_ready   = ready_r;
  assign bus.tx_serial  = serial_r;
  assign bus.tx_active  = active_r;
  assign bus.tx_done    = done_r;
  assign bus.overflow   = overflow_r;
  assign bus.fifo_count = count_r;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four instances (8N1 depth 4, 8E1, 8O1, 7N2) at 4 clocks per bit,
// each cycle of the line compared against a frame-level reference waveform.
module tb_uart_tx_fifo;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if_a ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(8)) if_b ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(8)) if_c ();
  uart_tx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(8)) if_d ();

  logic [3:0] dv = 4'b0000;
  logic [8:0] din [4];

  assign if_a.tx_dv = dv[0];
  assign if_b.tx_dv = dv[1];
  assign if_c.tx_dv = dv[2];
  assign if_d.tx_dv = dv[3];
  assign if_a.tx_byte = din[0][7:0];
  assign if_b.tx_byte = din[1][7:0];
  assign if_c.tx_byte = din[2][7:0];
  assign if_d.tx_byte = din[3][6:0];

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut_a (.i_Clock(clk), .i_Reset_n(rst_n), .bus(if_a));
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(8))
    dut_b (.i_Clock(clk), .i_Reset_n(rst_n), .bus(if_b));
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(8))
    dut_c (.i_Clock(clk), .i_Reset_n(rst_n), .bus(if_c));
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(8))
    dut_d (.i_Clock(clk), .i_Reset_n(rst_n), .bus(if_d));

  logic [3:0] ser_w, act_w, done_w, rdy_w, ovf_w;
  assign ser_w  = {if_d.tx_serial, if_c.tx_serial, if_b.tx_serial, if_a.tx_serial};
  assign act_w  = {if_d.tx_active, if_c.tx_active, if_b.tx_active, if_a.tx_active};
  assign done_w = {if_d.tx_done,   if_c.tx_done,   if_b.tx_done,   if_a.tx_done};
  assign rdy_w  = {if_d.tx_ready,  if_c.tx_ready,  if_b.tx_ready,  if_a.tx_ready};
  assign ovf_w  = {if_d.overflow,  if_c.overflow,  if_b.overflow,  if_a.overflow};

  typedef struct packed {
    logic [3:0] ser;
    logic [3:0] act;
    logic [3:0] done;
    logic       ovf;
    logic       rdy;
    logic [2:0] cnt;
  } smp_t;

  smp_t       log_q[$];
  smp_t       mon_s;
  logic       logging = 1'b0;
  logic [8:0] wr_bytes[$];
  logic [8:0] tx_bytes[$];
  logic       exp_ser[$], exp_act[$], exp_done[$];
  int         checks = 0;
  int         errors = 0;

  // One sample per clock, taken on the falling edge.
  always @(negedge clk) begin
    if (logging) begin
      mon_s.ser  = ser_w;
      mon_s.act  = act_w;
      mon_s.done = done_w;
      mon_s.ovf  = if_a.overflow;
      mon_s.rdy  = if_a.tx_ready;
      mon_s.cnt  = if_a.fifo_count;
      log_q.push_back(mon_s);
    end
  end

  function automatic int frame_len(input int dbits, input int par, input int sbits);
    return CPB * (1 + dbits + ((par != 0) ? 1 : 0) + sbits);
  endfunction

  // Reference line: two idle samples, then every byte of tx_bytes as contiguous frames.
  function automatic void build_expect(input int dbits, input int par, input int sbits, input int total);
    int   ends[$];
    logic bits[$];
    logic p;
    exp_ser.delete(); exp_act.delete(); exp_done.delete();
    repeat (2) begin exp_ser.push_back(1'b1); exp_act.push_back(1'b0); exp_done.push_back(1'b0); end
    foreach (tx_bytes[k]) begin
      bits.delete();
      bits.push_back(1'b0);
      p = 1'b0;
      for (int i = 0; i < dbits; i++) begin
        bits.push_back(tx_bytes[k][i]);
        p = p ^ tx_bytes[k][i];
      end
      if (par == 2) bits.push_back(p);
      else if (par == 1) bits.push_back(~p);
      for (int i = 0; i < sbits; i++) bits.push_back(1'b1);
      foreach (bits[j]) begin
        repeat (CPB) begin exp_ser.push_back(bits[j]); exp_act.push_back(1'b1); exp_done.push_back(1'b0); end
      end
      ends.push_back(exp_ser.size());
    end
    while (exp_ser.size() < total) begin
      exp_ser.push_back(1'b1); exp_act.push_back(1'b0); exp_done.push_back(1'b0);
    end
    foreach (ends[k]) exp_done[ends[k]] = 1'b1;
  endfunction

  // Write wr_bytes to instance d on consecutive cycles and log 'total' samples.
  task automatic send_and_log(input int d, input int total);
    @(posedge clk); #1;
    log_q.delete();
    logging = 1'b1;
    foreach (wr_bytes[k]) begin
      dv[d] = 1'b1;
      din[d] = wr_bytes[k];
      @(posedge clk); #1;
    end
    dv[d] = 1'b0;
    din[d] = 9'($urandom_range(0, 511));
    for (int g = 0; g < 5000 && log_q.size() < total; g++) @(posedge clk);
    #1 logging = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ser_w !== 4'hF) begin errors++; $display("FAIL reset_serial got %b required 1111", ser_w); end
    checks++; if (rdy_w !== 4'hF) begin errors++; $display("FAIL reset_ready got %b required 1111", rdy_w); end
    checks++; if (act_w !== 4'h0) begin errors++; $display("FAIL reset_active got %b required 0000", act_w); end
    checks++; if ((done_w | ovf_w) !== 4'h0) begin errors++; $display("FAIL reset_done_ovf got %b/%b required 0", done_w, ovf_w); end
    checks++;
    if ({if_a.fifo_count, if_b.fifo_count, if_c.fifo_count, if_d.fifo_count} !== 15'd0) begin
      errors++; $display("FAIL reset_count got %0d required 0", if_a.fifo_count);
    end
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++; if ({ser_w, act_w} !== 8'hF0) begin errors++; $display("FAIL post_reset_idle got ser=%b act=%b required 1111/0000", ser_w, act_w); end
  endtask

  task automatic test_single();
    int total;
    for (int r = 0; r < 3; r++) begin
      tx_bytes.delete();
      tx_bytes.push_back((r == 0) ? 9'h0A5 : 9'($urandom_range(0, 255)));
      wr_bytes = tx_bytes;
      total = 2 + frame_len(8, 0, 1) + 6;
      build_expect(8, 0, 1, total);
      send_and_log(0, total);
      checks++; if (log_q.size() !== total) begin errors++; $display("FAIL single_len got %0d required %0d", log_q.size(), total); end
      for (int i = 0; i < log_q.size() && i < total; i++) begin
        checks++;
        if ({log_q[i].ser[0], log_q[i].act[0], log_q[i].done[0]} !== {exp_ser[i], exp_act[i], exp_done[i]}) begin
          errors++;
          $display("FAIL single byte=%h cyc=%0d ser/act/done got %b%b%b required %b%b%b", tx_bytes[0], i,
                   log_q[i].ser[0], log_q[i].act[0], log_q[i].done[0], exp_ser[i], exp_act[i], exp_done[i]);
        end
      end
    end
  endtask

  task automatic test_parity();
    int total, par;
    logic [8:0] pat[3];
    pat[0] = 9'h0A5; pat[1] = 9'h007; pat[2] = 9'($urandom_range(0, 255));
    for (int d = 1; d <= 2; d++) begin
      par = (d == 1) ? 2 : 1;
      for (int r = 0; r < 3; r++) begin
        tx_bytes.delete();
        tx_bytes.push_back(pat[r]);
        wr_bytes = tx_bytes;
        total = 2 + frame_len(8, par, 1) + 6;
        build_expect(8, par, 1, total);
        send_and_log(d, total);
        checks++; if (log_q.size() !== total) begin errors++; $display("FAIL parity_len got %0d required %0d", log_q.size(), total); end
        for (int i = 0; i < log_q.size() && i < total; i++) begin
          checks++;
          if ({log_q[i].ser[d], log_q[i].act[d], log_q[i].done[d]} !== {exp_ser[i], exp_act[i], exp_done[i]}) begin
            errors++;
            $display("FAIL parity mode=%0d byte=%h cyc=%0d ser/act/done got %b%b%b required %b%b%b", par, pat[r], i,
                     log_q[i].ser[d], log_q[i].act[d], log_q[i].done[d], exp_ser[i], exp_act[i], exp_done[i]);
          end
        end
      end
    end
  endtask

  task automatic test_7n2();
    int total;
    for (int r = 0; r < 2; r++) begin
      tx_bytes.delete();
      tx_bytes.push_back((r == 0) ? 9'h055 : 9'($urandom_range(0, 127)));
      wr_bytes = tx_bytes;
      total = 2 + frame_len(7, 0, 2) + 6;
      build_expect(7, 0, 2, total);
      send_and_log(3, total);
      checks++; if (log_q.size() !== total) begin errors++; $display("FAIL s7n2_len got %0d required %0d", log_q.size(), total); end
      for (int i = 0; i < log_q.size() && i < total; i++) begin
        checks++;
        if ({log_q[i].ser[3], log_q[i].act[3], log_q[i].done[3]} !== {exp_ser[i], exp_act[i], exp_done[i]}) begin
          errors++;
          $display("FAIL s7n2 byte=%h cyc=%0d ser/act/done got %b%b%b required %b%b%b", tx_bytes[0], i,
                   log_q[i].ser[3], log_q[i].act[3], log_q[i].done[3], exp_ser[i], exp_act[i], exp_done[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int total, n;
    for (int r = 0; r < 2; r++) begin
      tx_bytes.delete();
      if (r == 0) begin
        tx_bytes.push_back(9'h011); tx_bytes.push_back(9'h022); tx_bytes.push_back(9'h033);
      end else begin
        n = $urandom_range(2, 4);
        for (int k = 0; k < n; k++) tx_bytes.push_back(9'($urandom_range(0, 255)));
      end
      wr_bytes = tx_bytes;
      total = 2 + tx_bytes.size() * frame_len(8, 0, 1) + 6;
      build_expect(8, 0, 1, total);
      send_and_log(0, total);
      checks++; if (log_q.size() !== total) begin errors++; $display("FAIL b2b_len got %0d required %0d", log_q.size(), total); end
      for (int i = 0; i < log_q.size() && i < total; i++) begin
        checks++;
        if ({log_q[i].ser[0], log_q[i].act[0], log_q[i].done[0]} !== {exp_ser[i], exp_act[i], exp_done[i]}) begin
          errors++;
          $display("FAIL b2b run=%0d cyc=%0d ser/act/done got %b%b%b required %b%b%b", r, i,
                   log_q[i].ser[0], log_q[i].act[0], log_q[i].done[0], exp_ser[i], exp_act[i], exp_done[i]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    int total, n, occ;
    logic exp_ovf[$], exp_rdy[$];
    int   exp_cnt[$];
    n = $urandom_range(6, 8);
    wr_bytes.delete(); tx_bytes.delete();
    for (int k = 0; k < n; k++) wr_bytes.push_back(9'($urandom_range(0, 255)));
    // Occupancy model: first byte leaves the FIFO one edge after it lands, nothing else pops meanwhile.
    occ = 0;
    exp_ovf.push_back(1'b0); exp_rdy.push_back(1'b1); exp_cnt.push_back(0);
    for (int k = 1; k <= n + 1; k++) begin
      exp_ovf.push_back((k <= n) && (occ == 4));
      if ((k <= n) && (occ != 4)) begin occ++; tx_bytes.push_back(wr_bytes[k-1]); end
      if (k == 2) occ--;
      exp_rdy.push_back(occ != 4);
      exp_cnt.push_back(occ);
    end
    total = 2 + tx_bytes.size() * frame_len(8, 0, 1) + 6;
    build_expect(8, 0, 1, total);
    while (exp_ovf.size() < total) exp_ovf.push_back(1'b0);
    send_and_log(0, total);
    checks++; if (tx_bytes.size() !== 5) begin errors++; $display("FAIL ovf_accepted got %0d required 5", tx_bytes.size()); end
    checks++; if (log_q.size() !== total) begin errors++; $display("FAIL ovf_len got %0d required %0d", log_q.size(), total); end
    for (int i = 0; i < log_q.size() && i < total; i++) begin
      checks++;
      if ({log_q[i].ser[0], log_q[i].act[0], log_q[i].done[0], log_q[i].ovf} !==
          {exp_ser[i], exp_act[i], exp_done[i], exp_ovf[i]}) begin
        errors++;
        $display("FAIL ovf_line cyc=%0d ser/act/done/ovf got %b%b%b%b required %b%b%b%b", i, log_q[i].ser[0],
                 log_q[i].act[0], log_q[i].done[0], log_q[i].ovf, exp_ser[i], exp_act[i], exp_done[i], exp_ovf[i]);
      end
      if (i <= n + 1) begin
        checks++;
        if ({log_q[i].rdy, log_q[i].cnt} !== {exp_rdy[i], 3'(exp_cnt[i])}) begin
          errors++;
          $display("FAIL ovf_fifo cyc=%0d ready/count got %b/%0d required %b/%0d", i, log_q[i].rdy, log_q[i].cnt,
                   exp_rdy[i], exp_cnt[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [8:0] b;
    b = 9'($urandom_range(0, 255));
    @(posedge clk); #1;
    dv[0] = 1'b1; din[0] = b;
    @(posedge clk); #1;
    dv[0] = 1'b0;
    repeat (17) @(posedge clk);
    #2;
    checks++; if ({if_a.tx_serial, if_a.tx_active} !== {b[3], 1'b1}) begin
      errors++; $display("FAIL mid_frame_bit3 got ser=%b act=%b required %b/1", if_a.tx_serial, if_a.tx_active, b[3]);
    end
    rst_n = 1'b0;
    #1;
    checks++; if ({if_a.tx_serial, if_a.tx_active, if_a.tx_ready, if_a.tx_done} !== 4'b1010) begin
      errors++; $display("FAIL async_reset ser/act/rdy/done got %b%b%b%b required 1010",
                         if_a.tx_serial, if_a.tx_active, if_a.tx_ready, if_a.tx_done);
    end
    checks++; if (if_a.fifo_count !== 3'd0) begin errors++; $display("FAIL async_reset_count got %0d required 0", if_a.fifo_count); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    log_q.delete();
    logging = 1'b1;
    repeat (60) @(posedge clk);
    #1 logging = 1'b0;
    checks++; if (log_q.size() !== 60) begin errors++; $display("FAIL post_abort_len got %0d required 60", log_q.size()); end
    foreach (log_q[i]) begin
      checks++;
      if ({log_q[i].ser[0], log_q[i].act[0], log_q[i].done[0]} !== 3'b100) begin
        errors++;
        $display("FAIL post_abort cyc=%0d ser/act/done got %b%b%b required 100", i,
                 log_q[i].ser[0], log_q[i].act[0], log_q[i].done[0]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) din[i] = 9'd0;
    test_reset();
    test_single();
    test_parity();
    test_7n2();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
